mcp3201_responder: RTL

MCP3201_RESPONDER -- requirements
Module: mcp3201_responder

---
 rtl/mcp3201_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mcp3201_responder.sv
// MCP3201 ADC slave emulator: answers SPI-style conversion frames from a
// master with a latched sample word, MSB-first followed by the LSB-first tail.
module mcp3201_responder #(
   parameter int RESOLUTION  = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  Reset_i,
   input  logic                  SCLK_i,
   input  logic                  nCS_i,
   input  logic [RESOLUTION-1:0] sample_i,
   output logic                  d_out_o,
   output logic                  d_out_oe_o,
   output logic [RESOLUTION-1:0] word_o,
   output logic                  frame_done_o,
   output logic                  frame_abort_o
);

   typedef enum logic [1:0] {
      WAIT_IDLE,
      IDLE,
      ACTIVE
   } state_t;

   // A frame is complete once the sample period, null bit and all MSB-first
   // data bits have been clocked out.
   localparam int FULL_LEN = RESOLUTION + 2;
   localparam int LAST_BIT = 2 * RESOLUTION + 1;

   logic [SYNC_STAGES-1:0] sclkSync_q;
   logic [SYNC_STAGES-1:0] ncsSync_q;
   logic                   sclkPrev_q;
   logic                   ncsPrev_q;
   logic [SYNC_STAGES:0]   settle_q;

   state_t                 state_q;
   logic [4:0]             nCount_q;
   logic [RESOLUTION-1:0]  word_q;
   logic                   dOut_q;
   logic                   oe_q;
   logic                   done_q;
   logic                   abort_q;

   logic                   sclkSync;
   logic                   ncsSync;
   logic                   sclkFall;
   logic                   ncsFall;
   logic                   ncsRise;
   logic [4:0]             nCount_d;
   logic                   dOut_d;

   // Serial data bit for falling-edge count n: two zeros, the word MSB first,
   // then bits 1..RESOLUTION-1 LSB first (B0 shared), then zeros.
   function automatic logic bitFor(input logic [4:0] n, input logic [RESOLUTION-1:0] w);
      int                    idx;
      logic                  sel;
      logic [RESOLUTION-1:0] sh;
      idx = 0;
      sel = 1'b0;
      if (int'(n) >= 3 && int'(n) <= RESOLUTION + 2) begin
         idx = RESOLUTION + 2 - int'(n);
         sel = 1'b1;
      end else if (int'(n) >= RESOLUTION + 3 && int'(n) <= LAST_BIT) begin
         idx = int'(n) - (RESOLUTION + 2);
         sel = 1'b1;
      end
      sh = w >> idx;
      return sel & sh[0];
   endfunction

   // Bring SCLK and nCS into the clk_i domain and keep one extra copy for edge
   // detection; settle_q marks when the nCS chain reflects the pin after reset.
   always_ff @(posedge clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         sclkSync_q <= '0;
         ncsSync_q  <= '1;
         sclkPrev_q <= 1'b0;
         ncsPrev_q  <= 1'b1;
         settle_q   <= '0;
      end else begin
         sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], SCLK_i};
         ncsSync_q  <= {ncsSync_q[SYNC_STAGES-2:0], nCS_i};
         sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
         ncsPrev_q  <= ncsSync_q[SYNC_STAGES-1];
         settle_q   <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // Edge detection plus the next count and next data bit for an SCLK fall.
   always_comb begin
      sclkSync = sclkSync_q[SYNC_STAGES-1];
      ncsSync  = ncsSync_q[SYNC_STAGES-1];
      sclkFall = sclkPrev_q & ~sclkSync;
      ncsFall  = ncsPrev_q & ~ncsSync;
      ncsRise  = ~ncsPrev_q & ncsSync;
      nCount_d = (nCount_q == 5'd31) ? nCount_q : nCount_q + 5'd1;
      dOut_d   = bitFor(nCount_d, word_q);
   end

   // Frame state machine; a chip-select edge always wins over a coincident
   // SCLK edge, and the reset value of the nCS chain is not trusted as "high".
   always_ff @(posedge clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         state_q  <= WAIT_IDLE;
         nCount_q <= 5'd0;
         word_q   <= '0;
         dOut_q   <= 1'b0;
         oe_q     <= 1'b0;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         case (state_q)
            WAIT_IDLE: begin
               if (settle_q[SYNC_STAGES] && ncsSync) begin
                  state_q <= IDLE;
               end
            end
            IDLE: begin
               if (ncsFall) begin
                  state_q  <= ACTIVE;
                  word_q   <= sample_i;
                  nCount_q <= 5'd0;
                  oe_q     <= 1'b1;
                  dOut_q   <= 1'b0;
               end
            end
            ACTIVE: begin
               if (ncsRise) begin
                  state_q <= IDLE;
                  oe_q    <= 1'b0;
                  dOut_q  <= 1'b0;
                  if (int'(nCount_q) >= FULL_LEN) begin
                     done_q <= 1'b1;
                  end else if (nCount_q != 5'd0) begin
                     abort_q <= 1'b1;
                  end
               end else if (sclkFall) begin
                  nCount_q <= nCount_d;
                  dOut_q   <= dOut_d;
               end
            end
            default: begin
               state_q <= WAIT_IDLE;
            end
         endcase
      end
   end

   assign d_out_o       = dOut_q;
   assign d_out_oe_o    = oe_q;
   assign word_o        = word_q;
   assign frame_done_o  = done_q;
   assign frame_abort_o = abort_q;

endmodule
